// File: rtl/rr_req_ctrl_if.sv
// rr_req_ctrl_if: job, request/grant and beat-report bundle
// between the requester controller and its environment.
interface rr_req_ctrl_if #(
  parameter int NCLI  = 4,
  parameter int LEN_W = 4
) ();
  localparam int CW = (NCLI > 1) ? $clog2(NCLI) : 1;

  logic [NCLI-1:0]       job_valid;
  logic [NCLI*LEN_W-1:0] job_len;
  logic [NCLI-1:0]       job_ready;
  logic [NCLI-1:0]       req;
  logic [NCLI-1:0]       granto;
  logic                  beat_valid;
  logic [CW-1:0]         beat_client;
  logic [LEN_W-1:0]      beat_idx;
  logic [NCLI-1:0]       done;
  logic                  grant_err;

  modport master (
    input  job_valid,
    input  job_len,
    input  granto,
    output job_ready,
    output req,
    output beat_valid,
    output beat_client,
    output beat_idx,
    output done,
    output grant_err
  );

  modport slave (
    output job_valid,
    output job_len,
    output granto,
    input  job_ready,
    input  req,
    input  beat_valid,
    input  beat_client,
    input  beat_idx,
    input  done,
    input  grant_err
  );
endinterface

// File: rtl/rr_req_ctrl.sv
// rr_req_ctrl: per-client burst requester in front of a
// round-robin arbiter, with grant protocol checking.
module rr_req_ctrl #(
  parameter int NCLI  = 4,
  parameter int LEN_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_req_ctrl_if.master bus
);
  localparam int CW = (NCLI > 1) ? $clog2(NCLI) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_REL
  } state_t;

  state_t           r_state  [NCLI];
  state_t           w_nstate [NCLI];
  logic [LEN_W-1:0] r_len    [NCLI];
  logic [LEN_W-1:0] w_nlen   [NCLI];
  logic [LEN_W-1:0] r_cnt    [NCLI];
  logic [LEN_W-1:0] w_ncnt   [NCLI];
  logic [NCLI-1:0]  r_req;
  logic [NCLI-1:0]  w_nreq;
  logic [NCLI-1:0]  w_qual;
  logic [NCLI-1:0]  w_ready;

  logic             w_multi;
  logic             w_noreq;
  logic             w_err;
  logic             w_beat;
  logic             w_last;
  logic [CW-1:0]    w_bcli;
  logic [LEN_W-1:0] w_bidx;

  logic             r_bv;
  logic [CW-1:0]    r_bcli;
  logic [LEN_W-1:0] r_bidx;
  logic [NCLI-1:0]  r_done;
  logic             r_err;

  // Grant legality: multi-hot, or a grant to a client not requesting
  always_comb begin
    w_multi = (bus.granto & (bus.granto - NCLI'(1))) != '0;
    w_noreq = |(bus.granto & ~r_req);
    w_err   = w_multi | w_noreq;
  end

  // A grant counts only if legal, owned, and the client is requesting
  always_comb begin
    w_qual = '0;
    for (int i = 0; i < NCLI; i++) begin
      w_qual[i] = !w_err && bus.granto[i] && r_req[i] &&
                  (r_state[i] == S_REQ || r_state[i] == S_XFER);
    end
  end

  // Pick out the single beating client, if any
  always_comb begin
    w_beat = |w_qual;
    w_bcli = '0;
    w_bidx = '0;
    w_last = 1'b0;
    for (int i = 0; i < NCLI; i++) begin
      if (w_qual[i]) begin
        w_bcli = CW'(i);
        w_bidx = r_cnt[i];
        w_last = (r_cnt[i] == r_len[i]);
      end
    end
  end

  // Per-client next state, counter and request
  always_comb begin
    for (int i = 0; i < NCLI; i++) begin
      w_nstate[i] = r_state[i];
      w_nlen[i]   = r_len[i];
      w_ncnt[i]   = r_cnt[i];
      unique case (r_state[i])
        S_IDLE: begin
          if (bus.job_valid[i]) begin
            w_nlen[i]   = bus.job_len[i*LEN_W +: LEN_W];
            w_ncnt[i]   = '0;
            w_nstate[i] = S_REQ;
          end
        end
        S_REQ, S_XFER: begin
          if (w_qual[i]) begin
            if (r_cnt[i] == r_len[i]) begin
              w_nstate[i] = S_REL;
            end else begin
              w_ncnt[i]   = r_cnt[i] + LEN_W'(1);
              w_nstate[i] = S_XFER;
            end
          end
        end
        S_REL: begin
          w_nstate[i] = S_IDLE;
        end
        default: begin
          w_nstate[i] = S_IDLE;
        end
      endcase
      w_nreq[i] = (w_nstate[i] == S_REQ) ||
                  (w_nstate[i] == S_XFER);
    end
  end

  // Per-client state, length, counter and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCLI; i++) begin
        r_state[i] <= S_IDLE;
        r_len[i]   <= '0;
        r_cnt[i]   <= '0;
      end
      r_req <= '0;
    end else begin
      for (int i = 0; i < NCLI; i++) begin
        r_state[i] <= w_nstate[i];
        r_len[i]   <= w_nlen[i];
        r_cnt[i]   <= w_ncnt[i];
      end
      r_req <= w_nreq;
    end
  end

  // Beat report, done pulse and sticky grant error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bv   <= 1'b0;
      r_bcli <= '0;
      r_bidx <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
    end else begin
      r_bv   <= w_beat;
      r_done <= '0;
      if (w_beat) begin
        r_bcli <= w_bcli;
        r_bidx <= w_bidx;
        if (w_last) begin
          r_done <= w_qual;
        end
      end
      if (w_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Ready is a direct decode of IDLE
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NCLI; i++) begin
      w_ready[i] = (r_state[i] == S_IDLE);
    end
  end

  assign bus.job_ready   = w_ready;
  assign bus.req         = r_req;
  assign bus.beat_valid  = r_bv;
  assign bus.beat_client = r_bcli;
  assign bus.beat_idx    = r_bidx;
  assign bus.done        = r_done;
  assign bus.grant_err   = r_err;
endmodule

// File: tb/tb_rr_req_ctrl.sv
// tb_rr_req_ctrl: directed checks of rr_req_ctrl with a
// manual grant driver and a small round-robin arbiter model.
module tb_rr_req_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  logic       use_arb;
  logic [3:0] man_gnt;
  logic [3:0] r_arb;
  logic [1:0] arb_ptr;

  rr_req_ctrl_if #(.NCLI(4), .LEN_W(4)) bus ();

  rr_req_ctrl #(.NCLI(4), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered round-robin grant, masked by the live request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arb   <= '0;
      arb_ptr <= '0;
    end else begin
      r_arb <= '0;
      for (int k = 3; k >= 0; k--) begin
        if (bus.req[2'(arb_ptr + 2'(k))]) begin
          r_arb   <= 4'b1 << (2'(arb_ptr + 2'(k)));
          arb_ptr <= 2'(arb_ptr + 2'(k) + 2'd1);
        end
      end
    end
  end

  assign bus.granto = use_arb ? (r_arb & bus.req) : man_gnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_idx [4];
  int n_beats;
  int n_done;
  int bc;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    use_arb = 1'b0;
    man_gnt = '0;
    bus.job_valid = '0;
    bus.job_len = '0;
    tick();

    // Reset state
    check("rst_req", bus.req, 4'h0);
    check("rst_bv", bus.beat_valid, 1'b0);
    check("rst_bc", bus.beat_client, 2'd0);
    check("rst_bi", bus.beat_idx, 4'd0);
    check("rst_done", bus.done, 4'h0);
    check("rst_err", bus.grant_err, 1'b0);
    check("rst_rdy", bus.job_ready, 4'hF);
    tick();
    rst = 1'b0;

    // Single-beat job on client 0
    bus.job_valid = 4'b0001;
    bus.job_len = 16'h0000;
    tick();
    bus.job_valid = '0;
    check("t1_req", bus.req, 4'b0001);
    check("t1_rdy0", bus.job_ready, 4'b1110);
    man_gnt = 4'b0001;
    tick();
    man_gnt = '0;
    check("t1_bv", bus.beat_valid, 1'b1);
    check("t1_bc", bus.beat_client, 2'd0);
    check("t1_bi", bus.beat_idx, 4'd0);
    check("t1_done", bus.done, 4'b0001);
    check("t1_reqoff", bus.req, 4'b0000);
    check("t1_rdyrel", bus.job_ready, 4'b1110);
    tick();
    check("t1_bv2", bus.beat_valid, 1'b0);
    check("t1_done2", bus.done, 4'b0000);
    check("t1_rdy", bus.job_ready, 4'hF);
    check("t1_err", bus.grant_err, 1'b0);

    // Four clients, 3 beats each, live arbiter
    use_arb = 1'b1;
    for (int i = 0; i < 4; i++) exp_idx[i] = 0;
    n_beats = 0;
    n_done = 0;
    bus.job_valid = 4'b1111;
    bus.job_len = 16'h2222;
    tick();
    bus.job_valid = '0;
    check("t2_req", bus.req, 4'b1111);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.beat_valid) begin
        bc = int'(bus.beat_client);
        n_beats++;
        check("t2_idx", bus.beat_idx, exp_idx[bc]);
        check("t2_dn", bus.done,
              (exp_idx[bc] == 2) ? (4'b1 << bc) : 4'b0);
        exp_idx[bc]++;
      end
      n_done += $countones(bus.done);
      if (bus.job_ready == 4'hF) break;
    end
    check("t2_rdy", bus.job_ready, 4'hF);
    check("t2_beats", n_beats, 12);
    check("t2_dones", n_done, 4);
    check("t2_err", bus.grant_err, 1'b0);
    for (int i = 0; i < 4; i++) check("t2_per", exp_idx[i], 3);
    use_arb = 1'b0;
    tick();

    // Client 2, grant gap of 3 cycles after beat 1
    bus.job_valid = 4'b0100;
    bus.job_len = 16'h0300;
    tick();
    bus.job_valid = '0;
    man_gnt = 4'b0100;
    tick();
    check("t3_b0", bus.beat_idx, 4'd0);
    tick();
    man_gnt = '0;
    check("t3_b1", bus.beat_idx, 4'd1);
    check("t3_bc", bus.beat_client, 2'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_gapbv", bus.beat_valid, 1'b0);
      check("t3_gapreq", bus.req[2], 1'b1);
    end
    man_gnt = 4'b0100;
    tick();
    check("t3_b2v", bus.beat_valid, 1'b1);
    check("t3_b2", bus.beat_idx, 4'd2);
    check("t3_d2", bus.done, 4'b0000);
    tick();
    man_gnt = '0;
    check("t3_b3", bus.beat_idx, 4'd3);
    check("t3_d3", bus.done, 4'b0100);
    check("t3_req", bus.req, 4'b0000);
    tick();
    check("t3_rdy", bus.job_ready, 4'hF);
    check("t3_err", bus.grant_err, 1'b0);

    // Multi-hot grant while clients 1 and 2 are in XFER
    bus.job_valid = 4'b0110;
    bus.job_len = 16'h0550;
    tick();
    bus.job_valid = '0;
    man_gnt = 4'b0010;
    tick();
    man_gnt = 4'b0100;
    tick();
    man_gnt = 4'b0110;
    tick();
    man_gnt = '0;
    check("t4_err", bus.grant_err, 1'b1);
    check("t4_bv", bus.beat_valid, 1'b0);
    check("t4_done", bus.done, 4'b0000);
    check("t4_req", bus.req, 4'b0110);
    man_gnt = 4'b0010;
    tick();
    check("t4_c1bc", bus.beat_client, 2'd1);
    check("t4_c1", bus.beat_idx, 4'd1);
    man_gnt = 4'b0100;
    tick();
    man_gnt = '0;
    check("t4_c2bc", bus.beat_client, 2'd2);
    check("t4_c2", bus.beat_idx, 4'd1);
    check("t4_sticky", bus.grant_err, 1'b1);
    do_reset();
    check("t4_clr", bus.grant_err, 1'b0);

    // Grant to a non-requesting client
    bus.job_valid = 4'b0001;
    bus.job_len = 16'h0003;
    tick();
    bus.job_valid = '0;
    check("t5_req", bus.req, 4'b0001);
    man_gnt = 4'b1000;
    tick();
    man_gnt = '0;
    check("t5_err", bus.grant_err, 1'b1);
    check("t5_bv", bus.beat_valid, 1'b0);
    do_reset();

    // Reset mid-burst on client 3, then a short job
    bus.job_valid = 4'b1000;
    bus.job_len = 16'hF000;
    tick();
    bus.job_valid = '0;
    man_gnt = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_idx", bus.beat_idx, k);
    end
    man_gnt = '0;
    rst = 1'b1;
    #2;
    check("t6_req", bus.req, 4'h0);
    check("t6_bv", bus.beat_valid, 1'b0);
    check("t6_bi", bus.beat_idx, 4'd0);
    check("t6_bc", bus.beat_client, 2'd0);
    check("t6_done", bus.done, 4'h0);
    check("t6_rdy", bus.job_ready, 4'hF);
    tick();
    rst = 1'b0;
    tick();
    check("t6_nodone", bus.done, 4'h0);
    bus.job_valid = 4'b1000;
    bus.job_len = 16'h1000;
    tick();
    bus.job_valid = '0;
    man_gnt = 4'b1000;
    tick();
    check("t6_n0", bus.beat_idx, 4'd0);
    check("t6_n0d", bus.done, 4'h0);
    tick();
    man_gnt = '0;
    check("t6_n1", bus.beat_idx, 4'd1);
    check("t6_n1c", bus.beat_client, 2'd3);
    check("t6_n1d", bus.done, 4'b1000);
    tick();
    check("t6_rdy2", bus.job_ready, 4'hF);
    check("t6_err", bus.grant_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
